// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed scan controller for a 4-digit common-anode
//               seven-segment display. Holds a 16-bit hex value plus four
//               decimal points and time-shares the segment bus between the
//               digits. Each digit slot opens with a blanking dead time
//               (all anodes off) to suppress ghosting. New values are
//               captured into a one-entry pending register and only
//               copied into the display register at the frame boundary
//               (digit 3 -> digit 0 wrap), so a frame never mixes old and
//               new digits.
//
// Ports       : clk     - system clock, rising edge
//               rst_n   - synchronous active-low reset
//               value   - hex value, [3:0] = digit 0 (rightmost)
//               dp_in   - decimal points, bit i = digit i, 1 = lit
//               lzb_en  - leading-zero blanking enable (captured with value)
//               load    - capture request for value/dp_in/lzb_en
//               ready   - a load can be accepted this cycle
//               code    - nibble of the active digit, to the hex decoder
//               seg_en  - 1 = decoder may drive segments, 0 = all off
//               dp_n    - decimal-point segment, active-low
//               dig_n   - anode selects, active-low, one-hot-low or all-high
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 12500,  // cycles per digit slot, 4..2^20
    parameter int BLANK_CYC   = 500     // dead-time cycles, 1..REFRESH_DIV-1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        lzb_en,
    input  logic        load,
    output logic        ready,
    output logic [3:0]  code,
    output logic        seg_en,
    output logic        dp_n,
    output logic [3:0]  dig_n
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_slot_last  = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_on    = 1'b1;

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_idx;

    logic [0:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [1:0]         w_idx_nxt;
    logic               w_wrap;

    // ------------------------------------------------------------------
    // Display / pending registers
    // ------------------------------------------------------------------
    logic [15:0] r_disp_val;
    logic [3:0]  r_disp_dp;
    logic        r_disp_lzb;

    logic [15:0] r_pend_val;
    logic [3:0]  r_pend_dp;
    logic        r_pend_lzb;
    logic        r_pend_vld;

    logic        w_accept;
    logic        w_apply;
    logic        w_pend_vld_nxt;

    // ------------------------------------------------------------------
    // Output registers and their combinational sources
    // ------------------------------------------------------------------
    logic        r_ready;
    logic [3:0]  r_code;
    logic        r_seg_en;
    logic        r_dp_n;
    logic [3:0]  r_dig_n;

    logic [3:0]  w_code;
    logic        w_seg_en;
    logic        w_dp_n;
    logic [3:0]  w_dig_n;
    logic [3:0]  w_lz;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_blank;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. The slot counter runs continuously across the
    // blank and lit phases of a slot, so BLANK ends at BLANK_CYC-1 and the
    // slot ends at REFRESH_DIV-1 without a second counter.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_one;
        w_idx_nxt   = r_idx;
        w_wrap      = 1'b0;

        case (r_state)
            c_st_blank: begin
                if (r_cnt == c_blank_last) begin
                    w_state_nxt = c_st_on;
                end
            end
            c_st_on: begin
                if (r_cnt == c_slot_last) begin
                    w_state_nxt = c_st_blank;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_wrap      = (r_idx == 2'd3);
                end
            end
            default: begin
                w_state_nxt = c_st_blank;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load handshake and frame-boundary apply. Accept needs an empty
    // pending slot and apply needs a full one, so the two never collide.
    // ------------------------------------------------------------------
    always_comb begin
        w_accept       = load && !r_pend_vld;
        w_apply        = w_wrap && r_pend_vld;
        w_pend_vld_nxt = r_pend_vld;
        if (w_accept) begin
            w_pend_vld_nxt = 1'b1;
        end else if (w_apply) begin
            w_pend_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_val <= 16'h0000;
            r_pend_dp  <= 4'h0;
            r_pend_lzb <= 1'b0;
            r_pend_vld <= 1'b0;
            r_disp_val <= 16'h0000;
            r_disp_dp  <= 4'h0;
            r_disp_lzb <= 1'b0;
        end else begin
            r_pend_vld <= w_pend_vld_nxt;
            if (w_accept) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
                r_pend_lzb <= lzb_en;
            end
            if (w_apply) begin
                r_disp_val <= r_pend_val;
                r_disp_dp  <= r_pend_dp;
                r_disp_lzb <= r_pend_lzb;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking: a digit is blanked when blanking is enabled
    // and it and every digit to its left are zero. The chain runs from
    // digit 3 downward; digit 0 always shows.
    // ------------------------------------------------------------------
    always_comb begin
        w_lz[3] = r_disp_lzb && (r_disp_val[15:12] == 4'h0);
        w_lz[2] = w_lz[3]    && (r_disp_val[11:8]  == 4'h0);
        w_lz[1] = w_lz[2]    && (r_disp_val[7:4]   == 4'h0);
        w_lz[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Output decode. The decoder nibble follows idx even while blank; the
    // segments are gated off by seg_en and the anodes, so it is harmless.
    // ------------------------------------------------------------------
    always_comb begin
        w_dig_n  = 4'b1111;
        w_seg_en = 1'b0;
        w_dp_n   = 1'b1;
        w_code   = r_disp_val[{r_idx, 2'b00} +: 4];

        if (r_state == c_st_on) begin
            w_dig_n[r_idx] = 1'b0;
            w_seg_en       = !w_lz[r_idx];
            w_dp_n         = !r_disp_dp[r_idx];
        end
    end

    // ------------------------------------------------------------------
    // Output registers. Every output shares the same one-cycle lag, so
    // anode changes stay aligned with the blank phase. ready tracks the
    // next value of the pending flag, i.e. it is the registered inverse
    // of pend_vld.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready  <= 1'b1;
            r_code   <= 4'h0;
            r_seg_en <= 1'b0;
            r_dp_n   <= 1'b1;
            r_dig_n  <= 4'b1111;
        end else begin
            r_ready  <= !w_pend_vld_nxt;
            r_code   <= w_code;
            r_seg_en <= w_seg_en;
            r_dp_n   <= w_dp_n;
            r_dig_n  <= w_dig_n;
        end
    end

    assign ready  = r_ready;
    assign code   = r_code;
    assign seg_en = r_seg_en;
    assign dp_n   = r_dp_n;
    assign dig_n  = r_dig_n;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl. Accepted loads are
//               queued as expected future display contents; a monitor
//               derives the expected scan position from the number of
//               clock edges since reset release and compares the outputs
//               every cycle, applying queued values at frame boundaries.
//               A second instance with a short slot checks anode safety.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int RD  = 8;
    localparam int BC  = 2;
    localparam int RD2 = 4;
    localparam int BC2 = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lzb_en;
    logic        load;

    logic        ready,   ready_b;
    logic [3:0]  code,    code_b;
    logic        seg_en,  seg_en_b;
    logic        dp_n,    dp_n_b;
    logic [3:0]  dig_n,   dig_n_b;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (value),
        .dp_in  (dp_in),
        .lzb_en (lzb_en),
        .load   (load),
        .ready  (ready),
        .code   (code),
        .seg_en (seg_en),
        .dp_n   (dp_n),
        .dig_n  (dig_n)
    );

    seg_scan_ctrl #(.REFRESH_DIV(RD2), .BLANK_CYC(BC2)) u_dut_fast (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (value),
        .dp_in  (dp_in),
        .lzb_en (lzb_en),
        .load   (load),
        .ready  (ready_b),
        .code   (code_b),
        .seg_en (seg_en_b),
        .dp_n   (dp_n_b),
        .dig_n  (dig_n_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic        lzb;
        int          acc;   // edge index at which the load was accepted
    } load_t;

    load_t       exp_q[$];
    int          nedges = -1;   // edges with rst_n high since last reset edge
    int          total  = 0;
    int          bad    = 0;
    logic [15:0] m_val  = 16'h0000;
    logic [3:0]  m_dp   = 4'h0;
    logic        m_lzb  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Stimulus capture: a load is taken when nothing is pending.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            nedges = 0;
        end else if (nedges >= 0) begin
            if (load && exp_q.size() == 0)
                exp_q.push_back('{val: value, dp: dp_in, lzb: lzb_en, acc: nedges});
            nedges++;
        end
    end

    // Monitor: outputs seen after edge p show the scan position p, where
    // every slot is RD cycles with the first BC dark, digits 0..3 in turn.
    always @(negedge clk) begin
        int p;
        int dig;
        bit lit;
        int nib;
        if (nedges >= 0) begin
            if (nedges == 0) begin
                m_val = 16'h0000;
                m_dp  = 4'h0;
                m_lzb = 1'b0;
            end
            p   = nedges - 1;
            lit = (nedges >= 1) && ((p % RD) >= BC);
            dig = (nedges >= 1) ? ((p / RD) % 4) : 0;
            nib = int'((m_val >> (4 * dig)) & 16'h000F);
            if (!lit) begin
                check("dig_n_dark", dig_n, 4'hF);
                check("seg_en_dark", seg_en, 0);
                check("dp_n_dark", dp_n, 1);
                if (nedges == 0)
                    check("code_reset", code, 0);
            end else begin
                check("dig_n_lit", dig_n, 4'hF ^ (4'h1 << dig));
                check("code_lit", code, nib);
                check("dp_n_lit", dp_n, !m_dp[dig]);
                check("seg_en_lit", seg_en,
                      !(m_lzb && dig != 0 && (m_val >> (4 * dig)) == 16'h0));
            end
            // The 3->0 wrap happens on edge p when p ends a frame.
            if (nedges >= 1 && (p % (4 * RD)) == 4 * RD - 1 &&
                exp_q.size() > 0 && exp_q[0].acc < p) begin
                m_val = exp_q[0].val;
                m_dp  = exp_q[0].dp;
                m_lzb = exp_q[0].lzb;
                void'(exp_q.pop_front());
            end
            check("ready", ready, exp_q.size() == 0);
        end
    end

    // Anode safety on the short-slot instance.
    always @(negedge clk) begin
        if (nedges >= 0) begin
            check("anode_onehot", $countones(~dig_n_b) <= 1, 1);
            check("seg_en_no_anode", seg_en_b && (dig_n_b == 4'hF), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lzb);
        load   = 1'b1;
        value  = v;
        dp_in  = dp;
        lzb_en = lzb;
        tick(1);
        load   = 1'b0;
    endtask

    task automatic wait_digit(input int d);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            if (nedges >= 1 && (((nedges - 1) / RD) % 4) == d && ((nedges - 1) % RD) == BC)
                found = 1'b1;
            else
                tick(1);
        end
        check("wait_digit_bound", found, 1);
    endtask

    initial begin
        logic [15:0] masks [5];
        masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        rst_n  = 1'b0;
        load   = 1'b0;
        value  = 16'h0000;
        dp_in  = 4'h0;
        lzb_en = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(40);

        do_load(16'h1234, 4'b0100, 1'b0);
        tick(100);
        do_load(16'h0070, 4'b0000, 1'b1);
        tick(80);
        do_load(16'h0000, 4'b0000, 1'b1);
        tick(80);

        // Load mid-frame, then a second load that must be ignored.
        wait_digit(1);
        do_load(16'hAAAA, 4'b1010, 1'b0);
        do_load(16'hBBBB, 4'b0101, 1'b0);
        tick(80);

        // Reset during digit 2 with a load still pending.
        wait_digit(0);
        do_load(16'h5555, 4'b1111, 1'b0);
        wait_digit(2);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(80);

        for (int i = 0; i < 700; i++) begin
            load   = ($urandom_range(0, 7) == 0);
            value  = 16'($urandom) & masks[$urandom_range(0, 4)];
            dp_in  = 4'($urandom);
            lzb_en = 1'($urandom);
            tick(1);
        end
        load = 1'b0;
        tick(80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Multiplexed scan controller for the board's 4-digit common-anode seven-segment display. Holds a 16-bit hex value plus four decimal points and time-shares the single segment bus between the four digits. Drives the active-low digit anode selects and a 4-bit code into the team's hex-to-segment decoder. Inserts a blanking dead time between digits to suppress ghosting, and applies new values only at frame boundaries so a frame never shows a mix of old and new digits.

## Interface

- `REFRESH_DIV`, 12500: clock cycles per digit slot (50 MHz gives 4 kHz per slot, 1 kHz per frame); legal range 4..2^20.
- `BLANK_CYC`, 500: cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYC < REFRESH_DIV.
- `clk` in 1: single system clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `value` in 16: hex value to show; [3:0] is the rightmost digit (digit 0), [15:12] is digit 3.
- `dp_in` in 4: decimal points, 1 = lit; bit i belongs to digit i.
- `lzb_en` in 1: leading-zero blanking enable; sampled together with `value`.
- `load` in 1: request to capture `value`, `dp_in` and `lzb_en`.
- `ready` out 1: high when a load can be accepted.
- `code` out 4: nibble of the active digit, to the hex decoder.
- `seg_en` out 1: 1 = decoder output may drive segments; 0 = force all segments off (1s, common anode).
- `dp_n` out 1: decimal-point segment, active-low.
- `dig_n` out 4: anode selects, active-low, one-hot-low or all-high.

## Operation

- **Registers**
  - Display register: `disp_val`, `disp_dp`, `disp_lzb`.
  - Pending register: `pend_*` with `pend_vld`.
  - Slot counter `cnt` (0..REFRESH_DIV-1), digit index `idx` (0..3), and state.
- **Handshake**
  - A load is accepted in a cycle where `load && ready` is true. That cycle captures the inputs into the pending register and sets `pend_vld`.
  - `ready = !pend_vld`.
  - `load` while `ready` is low is ignored. There is no queueing beyond one entry.
- **FSM states**
  - **BLANK**
    - `dig_n = 4'b1111`, `seg_en = 0`, `dp_n = 1`.
    - Moves to ON when `cnt == BLANK_CYC-1`.
  - **ON**
    - `dig_n[idx] = 0`, others 1.
    - `code = disp_val[4*idx +: 4]`.
    - `dp_n = !disp_dp[idx]`.
    - `seg_en = !lz(idx)`.
    - Moves to BLANK when `cnt == REFRESH_DIV-1`. On that transition `cnt` clears and `idx` increments, wrapping 3 to 0.
- **Frame-boundary apply**
  - When `idx` wraps 3 to 0 and `pend_vld = 1`, the pending register is copied into the display register and `pend_vld` clears in the same cycle.
  - So `ready` rises in the cycle after the wrap.
- **Simultaneous load and apply:** a load accepted in the same cycle as a wrap-apply cannot happen, because `ready` is low whenever `pend_vld` is set.
- **Leading-zero blanking `lz(i)`**
  - Requires `disp_lzb = 1`, `i != 0`, and every nibble from i through 3 equal to 0.
  - Digit 0 is never blanked.
  - The decimal point of a blanked digit still follows `disp_dp`.
- **Reset mid-scan:** returns to the reset state immediately on the next edge. The pending load is discarded and the display register clears to 0.

## Timing

- **Reset values**
  - `dig_n = 4'b1111`, `seg_en = 0`, `dp_n = 1`, `code = 0`, `ready = 1`.
  - State BLANK, `idx = 0`, `cnt = 0`.
  - Display and pending registers 0, `pend_vld = 0`.
- **Outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **Slot length:** exactly REFRESH_DIV cycles, split into BLANK_CYC blank cycles followed by REFRESH_DIV-BLANK_CYC lit cycles.
- **Frame length:** 4*REFRESH_DIV cycles.
- **First lit cycle after reset release:** digit 0 lights BLANK_CYC cycles after `rst_n` rises, allowing +1 for the output register.
- **Load-to-display latency:**
  - Minimum: 1 cycle to the pending register, then until the next 3-to-0 wrap, then the BLANK_CYC dead time.
  - Maximum: ≈ 4*REFRESH_DIV + BLANK_CYC + 2 cycles.
- **Anode timing:** anodes change only during BLANK. Two anodes are never low in the same cycle, and `seg_en` is never 1 while `dig_n` is all-high.

## Test plan

Use REFRESH_DIV=8 and BLANK_CYC=2 unless noted.

- **Reset:** hold `rst_n` = 0 for 3 cycles, then release. Outputs hold reset values. First `dig_n = 4'b1110` appears 2–3 cycles after release with `code = 0` and `seg_en = 1`.
- **Scan order:** load 16'h1234 with `dp_in = 4'b0100` and `lzb_en = 0`. Over one frame, `dig_n` goes 1110, 1101, 1011, 0111 with `code` 4, 3, 2, 1. `dp_n = 0` only during digit 2. Each slot has 2 all-high cycles and 6 lit cycles.
- **Leading-zero blanking:** load 16'h0070 with `lzb_en = 1`. Digits 3 and 2 have `seg_en = 0`, digit 1 shows 7, digit 0 shows 0. Load 16'h0000: only digit 0 is enabled and shows 0.
- **Handshake and tearing:**
  - Load 16'hAAAA mid-frame: `ready` drops the next cycle.
  - A second load 16'hBBBB while `ready` is low is ignored.
  - Display switches to A only at the 3-to-0 wrap, and `ready` rises the cycle after.
  - No frame mixes old and new digits.
- **Reset mid-frame:** assert `rst_n` = 0 during digit 2 with a pending load. Next cycle `dig_n = 4'b1111`, `ready = 1`. After release the display shows 0000 and the pending value never appears.
- **Anode assertion:** over 10 frames at REFRESH_DIV=4 and BLANK_CYC=1, `dig_n` never has more than one zero, and `seg_en = 1` never occurs with `dig_n = 4'b1111`.
